// File: rtl/ethernet_pkt_mux_n_if.sv
// Stream bundle for the N:1 egress mux: NUM_IN ingress lanes, one egress lane,
// source tag and sticky per-lane protocol-error flags.
interface ethernet_pkt_mux_n_if #(
    parameter int NUM_IN  = 5,
    parameter int DATA_W  = 512,
    parameter int EMPTY_W = 6
);
    localparam int SRC_W = $clog2(NUM_IN);

    logic [NUM_IN-1:0]         in_valid;
    logic [NUM_IN*DATA_W-1:0]  in_data;
    logic [NUM_IN-1:0]         in_sop;
    logic [NUM_IN-1:0]         in_eop;
    logic [NUM_IN*EMPTY_W-1:0] in_empty;
    logic [NUM_IN-1:0]         in_ready;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic                      out_sop;
    logic                      out_eop;
    logic [EMPTY_W-1:0]        out_empty;
    logic [SRC_W-1:0]          out_src;
    logic                      out_ready;
    logic                      out_almostfull;
    logic [NUM_IN-1:0]         err_nosop;

    modport master (
        output in_valid, in_data, in_sop, in_eop, in_empty, out_ready, out_almostfull,
        input  in_ready, out_valid, out_data, out_sop, out_eop, out_empty, out_src, err_nosop
    );

    modport slave (
        input  in_valid, in_data, in_sop, in_eop, in_empty, out_ready, out_almostfull,
        output in_ready, out_valid, out_data, out_sop, out_eop, out_empty, out_src, err_nosop
    );
endinterface

// File: rtl/ethernet_pkt_mux_n.sv
// Packet-atomic N:1 egress mux: round-robin or fixed-priority arbitration at
// packet boundaries, almost-full back-off, source tagging and no-SOP draining.
module ethernet_pkt_mux_n #(
    parameter int NUM_IN   = 5,
    parameter int DATA_W   = 512,
    parameter int EMPTY_W  = 6,
    parameter int ARB_MODE = 0
) (
    input logic               Clk,
    input logic               Rst_n,
    ethernet_pkt_mux_n_if.slave bus
);
    localparam int SRC_W = $clog2(NUM_IN);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t              state_q, state_d;
    logic [SRC_W-1:0]    grant_q, grant_d;
    logic [SRC_W-1:0]    ptr_q, ptr_d;
    logic [NUM_IN-1:0]   err_q, err_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_sop_q, out_sop_d;
    logic                out_eop_q, out_eop_d;
    logic [EMPTY_W-1:0]  out_empty_q, out_empty_d;
    logic [SRC_W-1:0]    out_src_q, out_src_d;

    logic [NUM_IN-1:0]   req, in_ready_c;
    logic [SRC_W-1:0]    win, idx;
    logic                found;
    logic                sel_valid, sel_sop, sel_eop;
    logic [DATA_W-1:0]   sel_data;
    logic [EMPTY_W-1:0]  sel_empty;

    assign req = bus.in_valid & bus.in_sop;

    // Round-robin scans from the pointer and wraps; fixed priority scans from lane 0.
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (ARB_MODE == 1) idx = SRC_W'(k);
            else               idx = SRC_W'((int'(ptr_q) + k) % NUM_IN);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_sop   = 1'b0;
        sel_eop   = 1'b0;
        sel_data  = '0;
        sel_empty = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant_q == SRC_W'(i)) begin
                sel_valid = bus.in_valid[i];
                sel_sop   = bus.in_sop[i];
                sel_eop   = bus.in_eop[i];
                sel_data  = bus.in_data[i*DATA_W +: DATA_W];
                sel_empty = bus.in_empty[i*EMPTY_W +: EMPTY_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        err_d       = err_q;
        in_ready_c  = '0;
        out_valid_d = out_valid_q & ~bus.out_ready;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_empty_d = out_empty_q;
        out_src_d   = out_src_q;
        case (state_q)
            IDLE: begin
                // Mid-packet beats seen between packets are swallowed and flagged.
                in_ready_c = bus.in_valid & ~bus.in_sop;
                err_d      = err_q | (bus.in_valid & ~bus.in_sop);
                if (found && !bus.out_almostfull) begin
                    grant_d = win;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                in_ready_c[grant_q] = ~out_valid_q | bus.out_ready;
                if (sel_valid && in_ready_c[grant_q]) begin
                    out_valid_d = 1'b1;
                    out_data_d  = sel_data;
                    out_sop_d   = sel_sop;
                    out_eop_d   = sel_eop;
                    out_empty_d = sel_empty;
                    out_src_d   = grant_q;
                    if (sel_eop) begin
                        state_d = IDLE;
                        ptr_d   = (grant_q == SRC_W'(NUM_IN-1)) ? '0 : grant_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            ptr_q       <= '0;
            err_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_empty_q <= '0;
            out_src_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ptr_q       <= ptr_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_empty_q <= out_empty_d;
            out_src_q   <= out_src_d;
        end
    end

    // Ready is held low while reset is asserted so nothing is consumed.
    assign bus.in_ready  = in_ready_c & {NUM_IN{Rst_n}};
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sop   = out_sop_q;
    assign bus.out_eop   = out_eop_q;
    assign bus.out_empty = out_empty_q;
    assign bus.out_src   = out_src_q;
    assign bus.err_nosop = err_q;
endmodule

// File: tb/tb_ethernet_pkt_mux_n.sv
// Directed bench for ethernet_pkt_mux_n: a round-robin instance driven by a
// packet source model, plus a fixed-priority instance driven by a short script.
module tb_ethernet_pkt_mux_n;
    localparam int N  = 5;
    localparam int DW = 512;
    localparam int EW = 6;

    logic Clk = 1'b0;
    logic Rst_n;
    always #5 Clk = ~Clk;

    ethernet_pkt_mux_n_if #(.NUM_IN(N), .DATA_W(DW), .EMPTY_W(EW)) bus_rr ();
    ethernet_pkt_mux_n_if #(.NUM_IN(N), .DATA_W(DW), .EMPTY_W(EW)) bus_fp ();

    ethernet_pkt_mux_n #(.NUM_IN(N), .DATA_W(DW), .EMPTY_W(EW), .ARB_MODE(0)) u_rr (
        .Clk(Clk), .Rst_n(Rst_n), .bus(bus_rr.slave));
    ethernet_pkt_mux_n #(.NUM_IN(N), .DATA_W(DW), .EMPTY_W(EW), .ARB_MODE(1)) u_fp (
        .Clk(Clk), .Rst_n(Rst_n), .bus(bus_fp.slave));

    typedef struct {
        int             src;
        logic [DW-1:0]  data;
        logic           sop;
        logic           eop;
        logic [EW-1:0]  empty;
        int             cyc;
    } beat_t;

    beat_t          log_q[$];
    int             n_chk = 0;
    int             n_pass = 0;
    int             cyc_n = 0;
    int             plen[N], pcnt[N], bidx[N], pnum[N];
    bit             bp_mode = 1'b0;
    bit             prev_stall = 1'b0;
    logic [DW-1:0]  prev_data;
    logic [EW-1:0]  prev_empty;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] mk(input int src, input int pkt, input int beat);
        return {16{8'(src), 8'(pkt), 8'(beat), 8'hA5}};
    endfunction

    function automatic logic [EW-1:0] mk_empty(input int src, input int beat);
        return EW'(src * 8 + beat);
    endfunction

    task automatic drive_src();
        logic [N-1:0]    v, s, e;
        logic [N*DW-1:0] d;
        logic [N*EW-1:0] em;
        v = '0; s = '0; e = '0; d = '0; em = '0;
        for (int i = 0; i < N; i++) begin
            if (pcnt[i] > 0) begin
                v[i] = 1'b1;
                s[i] = (bidx[i] == 0);
                e[i] = (bidx[i] == plen[i] - 1);
                d[i*DW +: DW] = mk(i, pnum[i], bidx[i]);
                em[i*EW +: EW] = mk_empty(i, bidx[i]);
            end
        end
        bus_rr.in_valid = v;
        bus_rr.in_sop   = s;
        bus_rr.in_eop   = e;
        bus_rr.in_data  = d;
        bus_rr.in_empty = em;
    endtask

    // One clock of the round-robin instance: drive, sample at negedge, advance sources.
    task automatic cyc();
        logic [N-1:0] acc;
        drive_src();
        if (bp_mode) bus_rr.out_ready = ~cyc_n[0];
        @(negedge Clk);
        acc = bus_rr.in_valid & bus_rr.in_ready;
        if (prev_stall) begin
            check("stall_vld", bus_rr.out_valid, 1);
            check("stall_data", bus_rr.out_data, prev_data);
            check("stall_empty", bus_rr.out_empty, prev_empty);
        end
        prev_stall = bus_rr.out_valid & ~bus_rr.out_ready;
        prev_data  = bus_rr.out_data;
        prev_empty = bus_rr.out_empty;
        if (bus_rr.out_valid && bus_rr.out_ready)
            log_q.push_back('{int'(bus_rr.out_src), bus_rr.out_data, bus_rr.out_sop,
                              bus_rr.out_eop, bus_rr.out_empty, cyc_n});
        @(posedge Clk);
        #1;
        cyc_n++;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                bidx[i]++;
                if (bidx[i] == plen[i]) begin
                    bidx[i] = 0;
                    pnum[i]++;
                    pcnt[i]--;
                end
            end
        end
    endtask

    task automatic run_until(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (log_q.size() < n && k < budget) begin
            cyc();
            k++;
        end
        check(tag, log_q.size(), n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int order[6];
        int start, af_drop;
        order = '{0, 2, 4, 0, 2, 4};
        for (int i = 0; i < N; i++) begin
            plen[i] = 1; pcnt[i] = 0; bidx[i] = 0; pnum[i] = 0;
        end

        // Reset with every input valid and a mix of sop flags.
        Rst_n = 1'b0;
        bus_rr.in_valid = '1; bus_rr.in_sop = 5'b01011; bus_rr.in_eop = '0;
        bus_rr.in_data = '1; bus_rr.in_empty = '1;
        bus_rr.out_ready = 1'b1; bus_rr.out_almostfull = 1'b0;
        bus_fp.in_valid = '1; bus_fp.in_sop = '1; bus_fp.in_eop = '1;
        bus_fp.in_data = '1; bus_fp.in_empty = '1;
        bus_fp.out_ready = 1'b1; bus_fp.out_almostfull = 1'b0;
        repeat (2) @(negedge Clk);
        check("rst_vld", bus_rr.out_valid, 0);
        check("rst_rdy", bus_rr.in_ready, 0);
        check("rst_err", bus_rr.err_nosop, 0);
        check("rst_data", bus_rr.out_data, 0);
        check("rst_src", bus_rr.out_src, 0);
        check("rst_sop_eop", {bus_rr.out_sop, bus_rr.out_eop}, 0);
        check("rst_empty", bus_rr.out_empty, 0);
        check("rst_fp_vld", bus_fp.out_valid, 0);
        check("rst_fp_rdy", bus_fp.in_ready, 0);
        bus_rr.in_valid = '0; bus_fp.in_valid = '0;
        bus_fp.in_sop = '0; bus_fp.in_eop = '0;
        @(posedge Clk); #1;
        Rst_n = 1'b1;

        // Round-robin over inputs 0, 2, 4 with two 3-beat packets each.
        plen[0] = 3; plen[2] = 3; plen[4] = 3;
        pcnt[0] = 2; pcnt[2] = 2; pcnt[4] = 2;
        start = cyc_n;
        run_until(18, 200, "rr_count");
        for (int p = 0; p < 6; p++) begin
            for (int b = 0; b < 3; b++) begin
                if (p*3 + b < log_q.size()) begin
                    check("rr_src", log_q[p*3+b].src, order[p]);
                    check("rr_data", log_q[p*3+b].data, mk(order[p], p / 3, b));
                    check("rr_sop", log_q[p*3+b].sop, b == 0);
                    check("rr_eop", log_q[p*3+b].eop, b == 2);
                    check("rr_empty", log_q[p*3+b].empty, mk_empty(order[p], b));
                end
            end
            if (p > 0 && p*3 < log_q.size())
                check("rr_gap", log_q[p*3].cyc - log_q[p*3-1].cyc, 2);
        end
        if (log_q.size() > 0) check("rr_latency", log_q[0].cyc - start, 2);
        cyc();
        log_q.delete();

        // Back-pressure: out_ready toggles during a 4-beat packet on input 1.
        plen[1] = 4; pcnt[1] = 1; bidx[1] = 0; pnum[1] = 0;
        bp_mode = 1'b1;
        prev_stall = 1'b0;
        run_until(4, 100, "bp_count");
        bp_mode = 1'b0;
        bus_rr.out_ready = 1'b1;
        for (int b = 0; b < 4 && b < log_q.size(); b++) begin
            check("bp_src", log_q[b].src, 1);
            check("bp_data", log_q[b].data, mk(1, 0, b));
            check("bp_empty", log_q[b].empty, mk_empty(1, b));
        end
        repeat (2) cyc();
        prev_stall = 1'b0;
        log_q.delete();

        // Almost-full holds off arbitration while idle.
        bus_rr.out_almostfull = 1'b1;
        plen[0] = 2; pcnt[0] = 1; bidx[0] = 0;
        repeat (4) cyc();
        check("af_hold_beats", log_q.size(), 0);
        check("af_hold_rdy", bus_rr.in_ready, 0);
        af_drop = cyc_n;
        bus_rr.out_almostfull = 1'b0;
        run_until(2, 20, "af_count");
        if (log_q.size() >= 2) begin
            check("af_grant_lat", log_q[0].cyc - af_drop, 2);
            check("af_data0", log_q[0].data, mk(0, 2, 0));
            check("af_data1", log_q[1].data, mk(0, 2, 1));
        end
        repeat (2) cyc();
        log_q.delete();

        // Almost-full rising mid-packet does not cut the packet.
        plen[3] = 4; pcnt[3] = 1; bidx[3] = 0;
        run_until(1, 20, "afmid_start");
        bus_rr.out_almostfull = 1'b1;
        run_until(4, 30, "afmid_count");
        for (int b = 0; b < 4 && b < log_q.size(); b++) begin
            check("afmid_src", log_q[b].src, 3);
            check("afmid_data", log_q[b].data, mk(3, 0, b));
        end
        bus_rr.out_almostfull = 1'b0;
        repeat (2) cyc();
        log_q.delete();

        // Beat without sop on input 2 while idle is drained and flagged.
        bus_rr.in_valid = 5'b00100; bus_rr.in_sop = '0; bus_rr.in_eop = '0;
        @(negedge Clk);
        check("drain_rdy", bus_rr.in_ready, 5'b00100);
        check("drain_vld", bus_rr.out_valid, 0);
        @(posedge Clk); #1;
        bus_rr.in_valid = '0;
        check("drain_err", bus_rr.err_nosop, 5'b00100);
        @(negedge Clk);
        check("drain_noout", bus_rr.out_valid, 0);
        @(posedge Clk); #1;

        // Fixed priority: inputs 1 and 3 request together, input 1 wins.
        bus_fp.in_valid = 5'b01010; bus_fp.in_sop = 5'b01010; bus_fp.in_eop = 5'b01010;
        bus_fp.in_data = '0;
        bus_fp.in_data[1*DW +: DW] = mk(1, 7, 0);
        bus_fp.in_data[3*DW +: DW] = mk(3, 7, 0);
        bus_fp.in_empty = '0;
        @(negedge Clk);
        check("fp_arb_rdy", bus_fp.in_ready, 0);
        @(posedge Clk); #1;
        @(negedge Clk);
        check("fp_rdy1", bus_fp.in_ready, 5'b00010);
        @(posedge Clk); #1;
        bus_fp.in_valid = 5'b01000;
        @(negedge Clk);
        check("fp_vld1", bus_fp.out_valid, 1);
        check("fp_src1", bus_fp.out_src, 1);
        check("fp_data1", bus_fp.out_data, mk(1, 7, 0));
        check("fp_idle_rdy", bus_fp.in_ready, 0);
        @(posedge Clk); #1;
        @(negedge Clk);
        check("fp_rdy3", bus_fp.in_ready, 5'b01000);
        check("fp_bubble", bus_fp.out_valid, 0);
        @(posedge Clk); #1;
        bus_fp.in_valid = '0;
        @(negedge Clk);
        check("fp_vld3", bus_fp.out_valid, 1);
        check("fp_src3", bus_fp.out_src, 3);
        check("fp_data3", bus_fp.out_data, mk(3, 7, 0));
        @(posedge Clk); #1;

        // Asynchronous reset in the middle of a packet.
        plen[1] = 4; pcnt[1] = 1; bidx[1] = 0; pnum[1] = 0;
        run_until(1, 20, "arst_start");
        check("arst_pre_vld", bus_rr.out_valid, 1);
        #2;
        Rst_n = 1'b0;
        #1;
        check("arst_vld", bus_rr.out_valid, 0);
        check("arst_rdy", bus_rr.in_ready, 0);
        check("arst_err", bus_rr.err_nosop, 0);
        bus_rr.in_valid = '0;
        @(posedge Clk); #1;
        Rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
